uart_tx_fifo: RTL

Synthesizable 8N1 UART transmitter with a small byte FIFO in front of it. Design logic pushes bytes in on the system clock. The block serializes them onto TX as LSB-first frames: start bit, 8 data bits, stop bit. TX is the line that drives the board/bench UART receiver, so it is the stage directly upstream of the UART receiver model.

---
 rtl/uart_tx_fifo_if.sv | 11 +
 rtl/uart_tx_fifo.sv | 95 +++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte-push handshake, status flags and serial line of the FIFO-fronted UART transmitter.
interface uart_tx_fifo_if;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic       busy;
   logic       TX;
   modport master (output wr_en, wr_data, input full, empty, busy, TX);
   modport slave (input wr_en, wr_data, output full, empty, busy, TX);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 LSB-first UART transmitter fed by a small byte FIFO.
module uart_tx_fifo #(
   parameter int CLK_FREQ     = 100_000_000,
   parameter int BAUD         = 115_200,
   parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
   parameter int FIFO_DEPTH   = 4,
   parameter int PTR_W        = $clog2(FIFO_DEPTH)
) (
   input logic          clk,
   input logic          rst,
   uart_tx_fifo_if.slave bus
);
   localparam int CW = PTR_W + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t           state_q, state_d;
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [BW-1:0]    baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d, push, pop, bit_end;
   assign bus.full  = count_q == CW'(FIFO_DEPTH);
   assign bus.empty = count_q == '0;
   assign bus.busy  = state_q != IDLE;
   assign bus.TX    = tx_q;
   // full is taken before any same-edge pop, so a write into a full FIFO is always dropped
   assign push    = bus.wr_en && !bus.full;
   assign bit_end = baud_q == BW'(CLKS_PER_BIT - 1);
   always_ff @(posedge clk)
      if (push) mem_q[wr_ptr_q] <= bus.wr_data;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + PTR_W'(push);
         rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
         count_q  <= count_q + CW'(push) - CW'(pop);
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   always_comb begin
      state_d = state_q;
      baud_d  = bit_end ? '0 : baud_q + BW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            tx_d   = bus.empty;
            if (!bus.empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               state_d = START;
            end
         end
         START: if (bit_end) begin
            state_d = DATA;
            bit_d   = '0;
            tx_d    = shift_q[0];
         end
         DATA: if (bit_end) begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = bit_q == 3'd7 ? 1'b1 : shift_q[1];
            state_d = bit_q == 3'd7 ? STOP : DATA;
         end
         STOP: if (bit_end) begin
            // chain straight into the next start bit when more bytes are queued
            pop     = !bus.empty;
            shift_d = bus.empty ? shift_q : mem_q[rd_ptr_q];
            tx_d    = bus.empty;
            state_d = bus.empty ? IDLE : START;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule
